// File: rtl/ysyx_cdb_arbiter_if.sv
// Common-data-bus bundle: per-unit completion requests in, one registered broadcast out.
// master is the arbiter side, slave is the execution-unit / ROB side.
interface ysyx_cdb_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int TAG_W = 5,
    parameter int XLEN  = 32
);
    localparam int SRC_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*TAG_W-1:0] req_dest;
    logic [N_REQ*XLEN-1:0]  req_result;
    logic [N_REQ*XLEN-1:0]  req_npc;
    logic [N_REQ-1:0]       req_pc_chg;

    logic                   cdb_valid;
    logic                   cdb_ready;
    logic [TAG_W-1:0]       cdb_dest;
    logic [XLEN-1:0]        cdb_result;
    logic [XLEN-1:0]        cdb_npc;
    logic                   cdb_pc_chg;
    logic [SRC_W-1:0]       cdb_src;

    modport master (
        input  req_valid, req_dest, req_result, req_npc, req_pc_chg, cdb_ready,
        output req_ready, cdb_valid, cdb_dest, cdb_result, cdb_npc, cdb_pc_chg, cdb_src
    );

    modport slave (
        output req_valid, req_dest, req_result, req_npc, req_pc_chg, cdb_ready,
        input  req_ready, cdb_valid, cdb_dest, cdb_result, cdb_npc, cdb_pc_chg, cdb_src
    );
endinterface

// File: rtl/ysyx_cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus among N_REQ execution units,
// with a one-entry registered broadcast stage toward the ROB / wakeup logic.
module ysyx_cdb_arbiter #(
    parameter int N_REQ = 3,
    parameter int TAG_W = 5,
    parameter int XLEN  = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    ysyx_cdb_arbiter_if.master bus
);
    localparam int SRC_W = $clog2(N_REQ);

    logic [SRC_W-1:0] rr_q, rr_d;
    logic             cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0] dest_q, dest_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [XLEN-1:0]  npc_q, npc_d;
    logic             pc_chg_q, pc_chg_d;
    logic [SRC_W-1:0] src_q, src_d;

    logic [TAG_W-1:0] dest_a   [N_REQ];
    logic [XLEN-1:0]  result_a [N_REQ];
    logic [XLEN-1:0]  npc_a    [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign dest_a[i]   = bus.req_dest[i*TAG_W +: TAG_W];
        assign result_a[i] = bus.req_result[i*XLEN +: XLEN];
        assign npc_a[i]    = bus.req_npc[i*XLEN +: XLEN];
    end

    logic             free;
    logic             found;
    logic [SRC_W-1:0] gidx;
    logic [SRC_W:0]   scan;
    logic [N_REQ-1:0] grant;

    // Scan from rr_q upward with wrap; the extra bit of scan absorbs the carry before wrapping.
    always_comb begin
        free  = !cdb_valid_q || bus.cdb_ready;
        found = 1'b0;
        gidx  = '0;
        scan  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan = {1'b0, rr_q} + (SRC_W+1)'(k);
            if (scan >= (SRC_W+1)'(N_REQ)) begin
                scan = scan - (SRC_W+1)'(N_REQ);
            end
            if (!found && bus.req_valid[scan[SRC_W-1:0]]) begin
                found = 1'b1;
                gidx  = scan[SRC_W-1:0];
            end
        end
        grant = '0;
        if (free && !flush && found) begin
            grant[gidx] = 1'b1;
        end
    end

    // Flush outranks both a ROB accept and a fresh grant; pointer only moves on a real grant.
    always_comb begin
        cdb_valid_d = cdb_valid_q;
        dest_d      = dest_q;
        result_d    = result_q;
        npc_d       = npc_q;
        pc_chg_d    = pc_chg_q;
        src_d       = src_q;
        rr_d        = rr_q;
        if (flush) begin
            cdb_valid_d = 1'b0;
        end else if (|grant) begin
            cdb_valid_d = 1'b1;
            dest_d      = dest_a[gidx];
            result_d    = result_a[gidx];
            npc_d       = npc_a[gidx];
            pc_chg_d    = bus.req_pc_chg[gidx];
            src_d       = gidx;
            rr_d        = (gidx == SRC_W'(N_REQ-1)) ? '0 : gidx + 1'b1;
        end else if (bus.cdb_ready) begin
            cdb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_valid_q <= 1'b0;
            dest_q      <= '0;
            result_q    <= '0;
            npc_q       <= '0;
            pc_chg_q    <= 1'b0;
            src_q       <= '0;
            rr_q        <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            dest_q      <= dest_d;
            result_q    <= result_d;
            npc_q       <= npc_d;
            pc_chg_q    <= pc_chg_d;
            src_q       <= src_d;
            rr_q        <= rr_d;
        end
    end

    assign bus.req_ready  = grant;
    assign bus.cdb_valid  = cdb_valid_q;
    assign bus.cdb_dest   = dest_q;
    assign bus.cdb_result = result_q;
    assign bus.cdb_npc    = npc_q;
    assign bus.cdb_pc_chg = pc_chg_q;
    assign bus.cdb_src    = src_q;
endmodule
